// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB initiator and its wait timer.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned APB_ADDR_WIDTH = 16;
  localparam int unsigned APB_BUS_WIDTH  = 32;

  // A zero timeout still needs a 1-bit counter to keep the port widths legal.
  function automatic int unsigned timer_width(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS-phase wait counter; flags the last permitted wait cycle.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned    W    = timer_width(TIMEOUT_CYCLES);
  localparam logic [W-1:0]   LAST = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0]   SAT  = W'(TIMEOUT_CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: the default comes first so no branch leaves cnt_d unassigned (no latch).
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking so every flop samples pre-edge values, whatever the order.
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero timeout disables the abort path entirely.
  assign expired_o = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);

endmodule

// File: rtl/apb_requester.sv
// APB4 initiator: turns valid/ready commands into SETUP/ACCESS transfers and
// returns a one-cycle response pulse with read data, slave error and timeout.
module apb_requester
  import apb_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter  int unsigned BUS_WIDTH      = APB_BUS_WIDTH,
  parameter  int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned STRB_WIDTH     = BUS_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [BUS_WIDTH-1:0]  req_wdata_i,
  input  logic [STRB_WIDTH-1:0] req_strb_i,
  output logic                  rsp_valid_o,
  output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_tout_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [STRB_WIDTH-1:0] pstrb_o,
  input  logic                  pready_i,
  input  logic [BUS_WIDTH-1:0]  prdata_i,
  input  logic                  pslverr_i
);

  apb_state_e            state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [BUS_WIDTH-1:0]  pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [BUS_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_tout_q, rsp_tout_d;

  logic accept;
  logic timer_expired;

  assign req_ready_o = (state_q == IDLE);
  assign accept      = req_ready_o && req_valid_i;

  apb_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (accept),
    .en_i      ((state_q == ACCESS) && !pready_i),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_tout_d  = rsp_tout_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          pwrite_d = req_write_i;
          paddr_d  = req_addr_i;
          // Reads drive zero data and strobes on the bus.
          pwdata_d = req_write_i ? req_wdata_i : '0;
          pstrb_d  = req_write_i ? req_strb_i  : '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // pready is checked first so it wins over a coincident timeout.
        if (pready_i) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (!pwrite_q && !pslverr_i) ? prdata_i : '0;
          rsp_err_d   = pslverr_i;
          rsp_tout_d  = 1'b0;
        end else if (timer_expired) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_tout_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tout_q  <= rsp_tout_d;
    end
  end

  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_tout_o  = rsp_tout_q;

endmodule
